// File: rtl/axi_lite_join_pipe.sv
// AXI-Lite register slice: per-channel FIFOs plus outstanding-transaction limiting.
// Define AXI_LITE_JOIN_PIPE_STALL_MON_EN to add the stall_o monitor output.

package axi_lite_join_pipe_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;
    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;
endpackage

module axi_lite_join_pipe_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);
    if (Depth == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign out_valid      = in_valid;
        assign in_ready       = out_ready;
        assign out_data       = in_data;
    end else begin : g_fifo
        localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW = $clog2(Depth + 1);

        logic [Width-1:0] mem [Depth];
        logic [PtrW-1:0]  wr_ptr, rd_ptr;
        logic [CntW-1:0]  count;
        logic             push, pop;

        // Readies held low during reset; full blocks a push even if a pop happens this cycle.
        assign in_ready  = rst_ni && (count != CntW'(Depth));
        assign out_valid = (count != '0);
        assign out_data  = mem[rd_ptr];
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end
endmodule

module axi_lite_join_pipe #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2,
    parameter int unsigned MaxTxns   = 8,
    parameter type req_t  = axi_lite_join_pipe_pkg::req_t,
    parameter type resp_t = axi_lite_join_pipe_pkg::resp_t,
    localparam int unsigned CntW = $clog2(MaxTxns + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  req_t            slv_req_i,
    output resp_t           slv_resp_o,
    output req_t            mst_req_o,
    input  resp_t           mst_resp_i,
    output logic [CntW-1:0] w_outst_o,
    output logic [CntW-1:0] r_outst_o
`ifdef AXI_LITE_JOIN_PIPE_STALL_MON_EN
    ,
    output logic            stall_o
`endif
);
    localparam int unsigned AxW = AddrWidth + 3;
    localparam int unsigned WW  = DataWidth + DataWidth / 8;
    localparam int unsigned BW  = 2;
    localparam int unsigned RW  = DataWidth + 2;

    logic [AxW-1:0] aw_data, ar_data;
    logic [WW-1:0]  w_data;
    logic [BW-1:0]  b_data;
    logic [RW-1:0]  r_data;
    logic aw_fifo_ready, aw_out_valid, w_in_ready, w_out_valid;
    logic ar_fifo_ready, ar_out_valid;
    logic b_in_ready, b_out_valid, r_in_ready, r_out_valid;
    logic aw_room, ar_room, aw_hs, ar_hs, b_hs, r_hs;
    logic [CntW-1:0] w_cnt, r_cnt;

    // A returning response this cycle frees a slot, so the limit is lifted early.
    assign b_hs    = b_out_valid && slv_req_i.b_ready;
    assign r_hs    = r_out_valid && slv_req_i.r_ready;
    assign aw_room = (w_cnt != CntW'(MaxTxns)) || b_hs;
    assign ar_room = (r_cnt != CntW'(MaxTxns)) || r_hs;
    assign aw_hs   = slv_req_i.aw_valid && aw_fifo_ready && aw_room;
    assign ar_hs   = slv_req_i.ar_valid && ar_fifo_ready && ar_room;

    axi_lite_join_pipe_fifo #(.Depth(Depth), .Width(AxW)) i_aw (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.aw_valid && aw_room), .in_ready(aw_fifo_ready), .in_data(slv_req_i.aw),
        .out_valid(aw_out_valid), .out_ready(mst_resp_i.aw_ready), .out_data(aw_data)
    );
    axi_lite_join_pipe_fifo #(.Depth(Depth), .Width(WW)) i_w (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.w_valid), .in_ready(w_in_ready), .in_data(slv_req_i.w),
        .out_valid(w_out_valid), .out_ready(mst_resp_i.w_ready), .out_data(w_data)
    );
    axi_lite_join_pipe_fifo #(.Depth(Depth), .Width(AxW)) i_ar (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.ar_valid && ar_room), .in_ready(ar_fifo_ready), .in_data(slv_req_i.ar),
        .out_valid(ar_out_valid), .out_ready(mst_resp_i.ar_ready), .out_data(ar_data)
    );
    axi_lite_join_pipe_fifo #(.Depth(Depth), .Width(BW)) i_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(mst_resp_i.b_valid), .in_ready(b_in_ready), .in_data(mst_resp_i.b),
        .out_valid(b_out_valid), .out_ready(slv_req_i.b_ready), .out_data(b_data)
    );
    axi_lite_join_pipe_fifo #(.Depth(Depth), .Width(RW)) i_r (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(mst_resp_i.r_valid), .in_ready(r_in_ready), .in_data(mst_resp_i.r),
        .out_valid(r_out_valid), .out_ready(slv_req_i.r_ready), .out_data(r_data)
    );

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_data;
        mst_req_o.aw_valid = aw_out_valid;
        mst_req_o.w        = w_data;
        mst_req_o.w_valid  = w_out_valid;
        mst_req_o.b_ready  = b_in_ready;
        mst_req_o.ar       = ar_data;
        mst_req_o.ar_valid = ar_out_valid;
        mst_req_o.r_ready  = r_in_ready;
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_fifo_ready && aw_room;
        slv_resp_o.w_ready  = w_in_ready;
        slv_resp_o.b        = b_data;
        slv_resp_o.b_valid  = b_out_valid;
        slv_resp_o.ar_ready = ar_fifo_ready && ar_room;
        slv_resp_o.r        = r_data;
        slv_resp_o.r_valid  = r_out_valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_cnt <= '0;
            r_cnt <= '0;
        end else begin
            if (aw_hs && !b_hs)                     w_cnt <= w_cnt + 1'b1;
            else if (b_hs && !aw_hs && w_cnt != '0) w_cnt <= w_cnt - 1'b1;
            if (ar_hs && !r_hs)                     r_cnt <= r_cnt + 1'b1;
            else if (r_hs && !ar_hs && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_outst_o = w_cnt;
    assign r_outst_o = r_cnt;

`ifdef AXI_LITE_JOIN_PIPE_STALL_MON_EN
    assign stall_o = rst_ni && ((slv_req_i.aw_valid && !slv_resp_o.aw_ready) ||
                                (slv_req_i.w_valid  && !slv_resp_o.w_ready)  ||
                                (slv_req_i.ar_valid && !slv_resp_o.ar_ready));
`endif

`ifndef SYNTHESIS
    a_b_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) b_hs |-> w_cnt != '0)
        else $error("B handshake with no outstanding write");
    a_r_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) r_hs |-> r_cnt != '0)
        else $error("R handshake with no outstanding read");
`endif
endmodule
